mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port ex_valid, input, 1: EX/MEM holds a valid instruction.
REQ-004 SHALL have port ex_alu_result, input, 32: ALU result, or byte base address for lw/sw.
REQ-005 SHALL have port ex_store_data, input, 32: sw source data (rs2).
REQ-006 SHALL have port ex_dest_reg, input, 5: destination register address.
REQ-007 SHALL have port ex_reg_write, input, 1: ALU-type op writes rd (add/sub/and/or/addi/sll/sra).
REQ-008 SHALL have ports ex_lw and ex_sw, input, 1 each: load word / store word.
REQ-009 SHALL have port stall, output, 1: upstream holds EX/MEM contents while high.
REQ-010 SHALL have port dmem_addr, output, 10: byte address to 8-bit data memory.
REQ-011 SHALL have port dmem_wdata, output, 8: store byte.
REQ-012 SHALL have port dmem_wr, output, 1: memory writes dmem_wdata at dmem_addr on rising edge while high.
REQ-013 SHALL have port dmem_rdata, input, 8: combinational read data for dmem_addr.
REQ-014 SHALL have ports wb_write (1), wb_data (32), wb_dest (5), outputs: register_bank write port (write, wr_data, destination_register).

Function
REQ-015 SHALL implement states IDLE, LOAD, STORE with a 2-bit byte index k.
REQ-016 In IDLE, an instruction SHALL be accepted at a rising edge only if ex_valid=1; capture base=ex_alu_result[9:0], store data, and dest.
REQ-017 Accept priority SHALL be ex_lw > ex_sw > ex_reg_write; none set -> no action.
REQ-018 Accepted ALU op: registered wb_write=1, wb_data=ex_alu_result, wb_dest=ex_dest_reg in the following cycle; state stays IDLE; stall stays 0.
REQ-019 Accepted lw at edge N: LOAD with k=0; at edges N+1..N+4 capture dmem_rdata into byte k (little-endian, byte k -> bits [8k+7:8k]), incrementing k.
REQ-020 At edge N+4 the lw SHALL assert wb_write=1 with the assembled word and captured dest for one cycle, then return to IDLE.
REQ-021 Accepted sw at edge N: STORE for cycles N..N+4, dmem_wr=1, dmem_wdata=store byte k; k increments at edges N+1..N+3; IDLE at edge N+4; wb_write stays 0.
REQ-022 In LOAD/STORE, dmem_addr SHALL be (base+k) mod 1024; wrap 0x3FF -> 0x000 without error.
REQ-023 stall SHALL be a registered 1 from the accept edge of lw/sw until edge N+4; the next instruction SHALL be accepted no earlier than edge N+5.
REQ-024 wb_write SHALL be a one-cycle pulse; wb_data/wb_dest SHALL hold their last values otherwise.
REQ-025 Any write with dest=0 SHALL suppress wb_write; the lw still performs all four reads.
REQ-026 In IDLE, dmem_addr=0, dmem_wdata=0, dmem_wr=0; dmem_wr SHALL never be 1 outside STORE.
REQ-027 ex_* inputs SHALL be ignored while state is not IDLE.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, k=0, stall=0, dmem_wr=0, wb_write=0, wb_data=0, wb_dest=0, captured registers=0.
REQ-029 Reset mid-lw/sw SHALL abort the operation with no wb_write and no further memory writes; bytes already written remain.
REQ-030 After reset_n rises, the first accept SHALL occur at the first rising edge with ex_valid=1.

Verification
REQ-031 ALU: ex_reg_write=1, ex_alu_result=0x00001234, dest=5 -> next cycle wb_write=1, wb_data=0x00001234, wb_dest=5, stall=0.
REQ-032 sw: base 0x100, data 0xDEADBEEF -> memory 0x100=EF, 0x101=BE, 0x102=AD, 0x103=DE; stall high 4 cycles; wb_write=0.
REQ-033 lw: base 0x100 after REQ-032, dest=7 -> wb_write pulse after edge N+4 with wb_data=0xDEADBEEF, wb_dest=7.
REQ-034 Wrap: sw base 0x3FE, data 0x11223344 -> 0x3FE=44, 0x3FF=33, 0x000=22, 0x001=11.
REQ-035 lw dest=0 followed back-to-back by ALU op dest=3 -> four reads, no wb_write for lw; ALU op accepted at edge N+5.
REQ-036 reset_n low after second sw byte -> dmem_wr=0 and stall=0 immediately; bytes 2-3 unwritten; IDLE after release.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU results go straight to writeback; lw/sw are serialised
// into four byte accesses on an 8-bit data memory, stalling upstream.
//
// state | meaning
// IDLE  | accepting instructions; memory port quiet
// LOAD  | reading byte k of the word at base+k, assembling little-endian
// STORE | writing byte k of the store data to base+k
module mem_wb_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_dest_reg,
  input  logic        ex_reg_write,
  input  logic        ex_lw,
  input  logic        ex_sw,
  output logic        stall,
  output logic [9:0]  dmem_addr,
  output logic [7:0]  dmem_wdata,
  output logic        dmem_wr,
  input  logic [7:0]  dmem_rdata,
  output logic        wb_write,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q;
  logic [9:0]  base_q;
  logic [31:0] sdata_q;
  logic [4:0]  dest_q;
  logic [23:0] lword_q;

  logic idle, accept_lw, accept_sw, accept_alu, accept_any, last_byte;

  assign idle       = (state_q == IDLE);
  assign accept_lw  = idle & ex_valid & ex_lw;
  assign accept_sw  = idle & ex_valid & ~ex_lw & ex_sw;
  assign accept_alu = idle & ex_valid & ~ex_lw & ~ex_sw & ex_reg_write;
  assign accept_any = accept_lw | accept_sw | accept_alu;
  assign last_byte  = (k_q == 2'd3);

  // State register; async reset aborts any in-flight memory operation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and memory port; the port is driven only while busy.
  always_comb begin
    state_d    = state_q;
    dmem_addr  = 10'd0;
    dmem_wdata = 8'd0;
    dmem_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_lw)      state_d = LOAD;
        else if (accept_sw) state_d = STORE;
      end
      LOAD: begin
        dmem_addr = base_q + 10'(k_q);
        if (last_byte) state_d = IDLE;
      end
      STORE: begin
        dmem_addr  = base_q + 10'(k_q);
        dmem_wdata = sdata_q[{k_q, 3'b000} +: 8];
        dmem_wr    = 1'b1;
        if (last_byte) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture registers, byte index, stall and the writeback port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_q      <= 2'd0;
      base_q   <= 10'd0;
      sdata_q  <= 32'd0;
      dest_q   <= 5'd0;
      lword_q  <= 24'd0;
      stall    <= 1'b0;
      wb_write <= 1'b0;
      wb_data  <= 32'd0;
      wb_dest  <= 5'd0;
    end else begin
      wb_write <= 1'b0;
      if (accept_any) begin
        base_q  <= ex_alu_result[9:0];
        sdata_q <= ex_store_data;
        dest_q  <= ex_dest_reg;
        k_q     <= 2'd0;
        lword_q <= 24'd0;
      end
      if (accept_lw || accept_sw) stall <= 1'b1;
      if (accept_alu && ex_dest_reg != 5'd0) begin
        wb_write <= 1'b1;
        wb_data  <= ex_alu_result;
        wb_dest  <= ex_dest_reg;
      end
      if (!idle) begin
        // k wraps 3 -> 0 on the final edge, leaving it cleared in IDLE.
        k_q <= k_q + 2'd1;
        if (state_q == LOAD) begin
          case (k_q)
            2'd0:    lword_q[7:0]   <= dmem_rdata;
            2'd1:    lword_q[15:8]  <= dmem_rdata;
            2'd2:    lword_q[23:16] <= dmem_rdata;
            default: ;
          endcase
        end
        if (last_byte) begin
          stall <= 1'b0;
          // Loads to x0 still perform all four reads but never write back.
          if (state_q == LOAD && dest_q != 5'd0) begin
            wb_write <= 1'b1;
            wb_data  <= {dmem_rdata, lword_q};
            wb_dest  <= dest_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a byte RAM, an expected-memory image and expected
// writeback values are maintained here and compared against the DUT.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_reg_write, ex_lw, ex_sw;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_dest_reg;
  logic        stall, dmem_wr, wb_write;
  logic [9:0]  dmem_addr;
  logic [7:0]  dmem_wdata, dmem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;

  logic [7:0]  ram     [1024];
  logic [7:0]  ref_mem [1024];
  logic [31:0] exp_wb_data;
  logic [4:0]  exp_wb_dest;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_wb_stage dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write),
    .ex_lw(ex_lw), .ex_sw(ex_sw), .stall(stall), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wr(dmem_wr), .dmem_rdata(dmem_rdata),
    .wb_write(wb_write), .wb_data(wb_data), .wb_dest(wb_dest)
  );

  always @(posedge clock) if (dmem_wr) ram[dmem_addr] <= dmem_wdata;
  assign dmem_rdata = ram[dmem_addr];

  task automatic drive_idle();
    ex_valid = 1'b0; ex_lw = 1'b0; ex_sw = 1'b0; ex_reg_write = 1'b0;
  endtask

  // Random instruction presented while the stage is busy; must be ignored.
  task automatic drive_junk();
    ex_valid      = 1'b1;
    ex_lw         = 1'($urandom);
    ex_sw         = 1'($urandom);
    ex_reg_write  = 1'($urandom);
    ex_alu_result = $urandom;
    ex_store_data = $urandom;
    ex_dest_reg   = 5'($urandom_range(1, 31));
  endtask

  // Called just after a falling edge; ends just after a falling edge.
  task automatic do_alu(input logic [31:0] val, input logic [4:0] dest);
    ex_valid = 1'b1; ex_lw = 1'b0; ex_sw = 1'b0; ex_reg_write = 1'b1;
    ex_alu_result = val; ex_dest_reg = dest; ex_store_data = $urandom;
    @(posedge clock); #1 drive_idle();
    @(negedge clock);
    if (dest != 5'd0) begin exp_wb_data = val; exp_wb_dest = dest; end
    n_checks++; if (wb_write !== (dest != 5'd0)) begin n_fail++;
      $display("FAIL alu_wb_write: got %b want %b", wb_write, dest != 5'd0); end
    n_checks++; if (wb_data !== exp_wb_data) begin n_fail++;
      $display("FAIL alu_wb_data: got %h want %h", wb_data, exp_wb_data); end
    n_checks++; if (wb_dest !== exp_wb_dest) begin n_fail++;
      $display("FAIL alu_wb_dest: got %0d want %0d", wb_dest, exp_wb_dest); end
    n_checks++; if (stall !== 1'b0) begin n_fail++;
      $display("FAIL alu_stall: got %b want 0", stall); end
    @(negedge clock);
    n_checks++; if (wb_write !== 1'b0) begin n_fail++;
      $display("FAIL alu_pulse_end: got %b want 0", wb_write); end
  endtask

  task automatic do_sw(input logic [9:0] base, input logic [31:0] data,
                       input bit also_alu, input bit junk);
    logic [9:0] a;
    ex_valid = 1'b1; ex_lw = 1'b0; ex_sw = 1'b1; ex_reg_write = also_alu;
    ex_alu_result = {22'($urandom), base}; ex_store_data = data;
    ex_dest_reg = 5'($urandom);
    @(posedge clock); #1 if (junk) drive_junk(); else drive_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a = 10'((int'(base) + i) % 1024);
      n_checks++; if (stall !== 1'b1 || dmem_wr !== 1'b1 || wb_write !== 1'b0) begin
        n_fail++; $display("FAIL sw_ctrl[%0d]: got stall=%b wr=%b wb=%b want 1 1 0",
                           i, stall, dmem_wr, wb_write); end
      n_checks++; if (dmem_addr !== a) begin n_fail++;
        $display("FAIL sw_addr[%0d]: got %h want %h", i, dmem_addr, a); end
      n_checks++; if (dmem_wdata !== data[8*i +: 8]) begin n_fail++;
        $display("FAIL sw_wdata[%0d]: got %h want %h", i, dmem_wdata, data[8*i +: 8]); end
      ref_mem[a] = data[8*i +: 8];
      if (junk) drive_junk();
    end
    @(negedge clock); drive_idle();
    n_checks++; if (stall !== 1'b0 || dmem_wr !== 1'b0 || dmem_addr !== 10'd0 ||
                    dmem_wdata !== 8'd0 || wb_write !== 1'b0) begin
      n_fail++; $display("FAIL sw_done: got stall=%b wr=%b addr=%h wdata=%h wb=%b want all 0",
                         stall, dmem_wr, dmem_addr, dmem_wdata, wb_write); end
    for (int i = 0; i < 4; i++) begin
      a = 10'((int'(base) + i) % 1024);
      n_checks++; if (ram[a] !== ref_mem[a]) begin n_fail++;
        $display("FAIL sw_mem[%h]: got %h want %h", a, ram[a], ref_mem[a]); end
    end
  endtask

  // Ends just after the falling edge following the final read edge, with
  // ex_valid low, so a caller may issue the next instruction immediately.
  task automatic do_lw(input logic [9:0] base, input logic [4:0] dest,
                       input bit prio, input bit junk);
    logic [9:0]  a;
    logic [31:0] word;
    ex_valid = 1'b1; ex_lw = 1'b1; ex_sw = prio; ex_reg_write = prio;
    ex_alu_result = {22'($urandom), base}; ex_store_data = $urandom;
    ex_dest_reg = dest;
    @(posedge clock); #1 if (junk) drive_junk(); else drive_idle();
    word = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      a = 10'((int'(base) + i) % 1024);
      word = word + (32'(ref_mem[a]) << (8 * i));
      n_checks++; if (stall !== 1'b1 || dmem_wr !== 1'b0 || wb_write !== 1'b0) begin
        n_fail++; $display("FAIL lw_ctrl[%0d]: got stall=%b wr=%b wb=%b want 1 0 0",
                           i, stall, dmem_wr, wb_write); end
      n_checks++; if (dmem_addr !== a) begin n_fail++;
        $display("FAIL lw_addr[%0d]: got %h want %h", i, dmem_addr, a); end
      if (junk) drive_junk();
    end
    @(negedge clock); drive_idle();
    if (dest != 5'd0) begin exp_wb_data = word; exp_wb_dest = dest; end
    n_checks++; if (wb_write !== (dest != 5'd0)) begin n_fail++;
      $display("FAIL lw_wb_write: got %b want %b", wb_write, dest != 5'd0); end
    n_checks++; if (wb_data !== exp_wb_data) begin n_fail++;
      $display("FAIL lw_wb_data: got %h want %h", wb_data, exp_wb_data); end
    n_checks++; if (wb_dest !== exp_wb_dest) begin n_fail++;
      $display("FAIL lw_wb_dest: got %0d want %0d", wb_dest, exp_wb_dest); end
    n_checks++; if (stall !== 1'b0 || dmem_addr !== 10'd0) begin n_fail++;
      $display("FAIL lw_done: got stall=%b addr=%h want 0 0", stall, dmem_addr); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; drive_idle();
    ex_alu_result = 32'd0; ex_store_data = 32'd0; ex_dest_reg = 5'd0;
    repeat (2) @(negedge clock);
    n_checks++; if (stall !== 1'b0 || dmem_wr !== 1'b0 || wb_write !== 1'b0 ||
                    wb_data !== 32'd0 || wb_dest !== 5'd0 || dmem_addr !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs: got stall=%b wr=%b wb=%b data=%h dest=%0d addr=%h want 0",
                         stall, dmem_wr, wb_write, wb_data, wb_dest, dmem_addr); end
    exp_wb_data = 32'd0; exp_wb_dest = 5'd0;
    reset_n = 1'b1;
  endtask

  task automatic test_alu();
    do_alu(32'h0000_1234, 5'd5);
    do_alu(32'hCAFE_0001, 5'd0);
    do_alu(32'h8000_0000, 5'd31);
  endtask

  task automatic test_no_valid();
    ex_valid = 1'b0; ex_lw = 1'b1; ex_sw = 1'b1; ex_reg_write = 1'b1;
    ex_dest_reg = 5'd9; ex_alu_result = 32'h55;
    @(posedge clock); #1 drive_idle();
    @(negedge clock);
    n_checks++; if (stall !== 1'b0 || wb_write !== 1'b0 || dmem_wr !== 1'b0) begin
      n_fail++; $display("FAIL no_valid: got stall=%b wb=%b wr=%b want 0 0 0",
                         stall, wb_write, dmem_wr); end
  endtask

  task automatic test_sw_lw();
    do_sw(10'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_lw(10'h100, 5'd7, 1'b0, 1'b0);
    @(negedge clock);
    n_checks++; if (wb_write !== 1'b0) begin n_fail++;
      $display("FAIL lw_pulse_end: got %b want 0", wb_write); end
  endtask

  task automatic test_wrap();
    do_sw(10'h3FE, 32'h1122_3344, 1'b1, 1'b1);
    do_lw(10'h3FF, 5'd12, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_lw(10'h100, 5'd0, 1'b0, 1'b0);
    do_alu(32'h0000_0ABC, 5'd3);
  endtask

  task automatic test_reset_mid();
    logic [31:0] data;
    data = 32'hA1B2_C3D4;
    ex_valid = 1'b1; ex_lw = 1'b0; ex_sw = 1'b1; ex_reg_write = 1'b0;
    ex_alu_result = 32'h0000_0200; ex_store_data = data; ex_dest_reg = 5'd4;
    @(posedge clock); #1 drive_idle();
    repeat (3) @(negedge clock);
    ref_mem[10'h200] = data[7:0];
    ref_mem[10'h201] = data[15:8];
    reset_n = 1'b0; #1;
    n_checks++; if (dmem_wr !== 1'b0 || stall !== 1'b0 || wb_write !== 1'b0 ||
                    wb_data !== 32'd0 || dmem_addr !== 10'd0) begin
      n_fail++; $display("FAIL reset_mid: got wr=%b stall=%b wb=%b data=%h addr=%h want 0",
                         dmem_wr, stall, wb_write, wb_data, dmem_addr); end
    exp_wb_data = 32'd0; exp_wb_dest = 5'd0;
    @(negedge clock); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ram[10'h200 + 10'(i)] !== ref_mem[10'h200 + 10'(i)]) begin n_fail++;
        $display("FAIL reset_mid_mem[%0d]: got %h want %h", i,
                 ram[10'h200 + 10'(i)], ref_mem[10'h200 + 10'(i)]); end
    end
    do_alu(32'h0000_7777, 5'd8);
  endtask

  task automatic test_random();
    int kind;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      case (kind)
        0: do_alu($urandom, 5'($urandom));
        1: do_sw(10'($urandom), $urandom, 1'($urandom), 1'($urandom));
        default: do_lw(10'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    test_reset();
    test_alu();
    test_no_valid();
    test_sw_lw();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
